arbiter_8_way: RTL
==================

# arbiter_8_way

Round-robin arbiter that shares one resource among eight requesters. The any-request test is the 8-way OR reduction of the request vector, so `or_8_way` is the front end. One grant is issued at a time and held until the owner releases it, withdraws its request, or exceeds a hold limit. The block sits between eight request lines and a single shared datapath port, for example a memory or bus, and sequences ownership of that port.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one grant may be held. 0 disables the limit. Legal range 0..255.
- `clk` input, 1: rising-edge clock, the only clock.
- `reset` input, 1: synchronous, active-high reset, sampled on the `clk` rising edge.
- `req` input, 8: per-requester request level. Bit i is requester i.
- `rel` input, 1: current owner releases the grant. Ignored while no grant is active.
- `any_req` output, 1: combinational OR of `req`, through `or_8_way`.
- `grant` output, 8: registered one-hot grant, or 0 when there is no owner.
- `grant_idx` output, 3: binary index of the owner. Holds its last value while `grant_valid` is 0.
- `grant_valid` output, 1: registered. Equals `|grant`.
- `timeout` output, 1: registered one-cycle pulse when a grant is forcibly removed by `MAX_HOLD`.

## Operation
- State `IDLE`: no owner.
  - If `any_req` is 1, select the first set `req` bit, searching upward from `ptr` modulo 8.
  - Load `grant`, `grant_idx`, set `grant_valid`, set hold counter `hcnt` to 1, go to `GRANTED`.
  - If `any_req` is 0, stay in `IDLE`.
- State `GRANTED`: `grant` is stable.
  - Drop conditions are evaluated each cycle: `rel`=1, `req[grant_idx]`=0, or (`MAX_HOLD`≠0 and `hcnt`==`MAX_HOLD`).
  - If any drop condition holds: clear `grant` and `grant_valid`, set `ptr` to `grant_idx`+1 mod 8, go to `IDLE`.
  - Otherwise `hcnt` increments, saturating at `MAX_HOLD`.
- `timeout` is set for one cycle, at the same edge that clears the grant, only when the hold limit is the sole drop cause. If `rel` or the request drop occurs in the same cycle, `timeout` stays 0.
- Pointer `ptr` (3 bits, reset 0) gives fairness: the last owner has lowest priority on the next arbitration. The search wraps from 7 to 0.
- Grants are never back-to-back. At least one `IDLE` cycle always separates two grants, including a re-grant to the same requester.
- `hcnt` width is 8 bits. It is compared with `MAX_HOLD` at full width.
- Requests from non-owners never affect the current grant. There is no preemption.
- `reset`=1 in any state: next edge gives state `IDLE`, `grant`=0, `grant_valid`=0, `grant_idx`=0, `timeout`=0, `ptr`=0, `hcnt`=0. Any grant in flight is dropped with no `timeout` pulse.

## Timing
- Reset values of outputs: `grant`=0, `grant_idx`=0, `grant_valid`=0, `timeout`=0. `any_req` follows `req` combinationally, even while `reset` is high.
- Request latency: `req` sampled at edge N in `IDLE` gives `grant` visible after edge N+1, i.e. one cycle.
- Release latency: `rel` or request drop sampled at edge M gives `grant`=0 after edge M+1. The earliest next grant is after edge M+2.
- A grant held to the limit is high for exactly `MAX_HOLD` cycles.
- Full-occupancy throughput: one grant per 2 cycles when every owner releases immediately.
- `rel` asserted in `IDLE`, or coincident with a new grant being issued, is ignored. It does not cancel the new grant.

## Test plan
- Reset: drive `req`=8'hFF and `reset`=1 for 3 cycles -> `grant`=0, `grant_valid`=0, `grant_idx`=0, `timeout`=0 throughout, and `any_req`=1.
- Single requester: `req`=8'b00000100 from cycle 1, `rel` pulsed at cycle 5 -> `grant`=8'b00000100 and `grant_idx`=2 from cycle 2 through 5, `grant`=0 at cycle 6, re-grant to 2 at cycle 7.
- Round robin: `req`=8'hFF held, `rel` pulsed in every `GRANTED` cycle -> `grant_idx` sequence 0,1,2,3,4,5,6,7,0, each one-hot, separated by single idle cycles.
- Pointer wrap: after a grant to 6 is released, `req`=8'b01000001 -> next grant is index 0, then index 6 after that release.
- Timeout with `MAX_HOLD`=4: `req`=8'b00001000 held, `rel`=0 -> `grant_valid` high for exactly 4 cycles, `timeout`=1 for one cycle at the drop, re-grant to 3 after one idle cycle. Repeat with `rel`=1 in the 4th cycle -> drop with `timeout`=0.
- Withdraw and reset mid-grant:
  - Owner 5 clears `req[5]` while `req[1]` is set -> grant drops next cycle, then 1 is granted.
  - Assert `reset` during a grant -> all outputs return to reset values after the next edge, and arbitration restarts from `ptr`=0.

Source files
------------

// File: rtl/arbiter_8_way_if.sv
// Bundle of the request/grant signals shared between eight requesters and the
// round-robin arbiter.
//   req[7:0]       requester -> arbiter, request level per requester
//   rel            requester -> arbiter, current owner releases the grant
//   any_req        arbiter -> requester, OR of all request lines
//   grant[7:0]     arbiter -> requester, one-hot grant (0 when no owner)
//   grant_idx[2:0] arbiter -> requester, binary index of the owner
//   grant_valid    arbiter -> requester, a grant is active
//   timeout        arbiter -> requester, one-cycle pulse on a hold-limit drop
interface arbiter_8_way_if;
    logic [7:0] req;
    logic       rel;
    logic       any_req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    // Requester side drives requests and release, observes the grant.
    modport master (
        output req, rel,
        input  any_req, grant, grant_idx, grant_valid, timeout
    );

    // Arbiter side observes requests and release, drives the grant.
    modport slave (
        input  req, rel,
        output any_req, grant, grant_idx, grant_valid, timeout
    );
endinterface

// File: rtl/arbiter_8_way.sv
// Round-robin arbiter sharing one resource among eight requesters. One grant
// is issued at a time and held until the owner releases it, withdraws its
// request, or reaches the MAX_HOLD limit (0 disables the limit). At least one
// idle cycle separates consecutive grants.
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    arbiter_8_way_if.slave: req/rel in, any_req/grant/grant_idx/
//          grant_valid/timeout out (all outputs registered except any_req)

// 8-input OR reduction used as the any-request front end.
module or_8_way (
    input  logic [7:0] in_i,
    output logic       out_o
);
    assign out_o = |in_i;
endmodule

module arbiter_8_way #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               reset,
    arbiter_8_way_if.slave     bus
);
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_e;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    localparam bit         LIMIT_EN   = (MAX_HOLD != 32'd0);
    // With the limit disabled the counter still must not wrap back to 0.
    localparam logic [7:0] HOLD_SAT   = LIMIT_EN ? HOLD_LIMIT : 8'hFF;

    state_e     state_q;
    logic [2:0] ptr_q;
    logic [7:0] hcnt_q;
    logic [7:0] hcnt_d;
    logic [7:0] grant_q;
    logic [2:0] grant_idx_q;
    logic       grant_valid_q;
    logic       timeout_q;

    logic       any_req_s;
    logic [2:0] sel_idx_s;
    logic       drop_rel_s;
    logic       drop_req_s;
    logic       drop_lim_s;
    logic       drop_s;

    or_8_way u_or (
        .in_i  (bus.req),
        .out_o (any_req_s)
    );

    assign bus.any_req     = any_req_s;
    assign bus.grant       = grant_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.timeout     = timeout_q;

    // Rotating priority search: the first set request at or above ptr wins.
    // Scanning offsets from high to low lets the smallest offset overwrite.
    always_comb begin
        sel_idx_s = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            if (bus.req[ptr_q + 3'(k)]) begin
                sel_idx_s = ptr_q + 3'(k);
            end else begin
                sel_idx_s = sel_idx_s;
            end
        end
    end

    // Drop causes for the current owner, plus the saturating hold count.
    always_comb begin
        drop_rel_s = bus.rel;
        drop_req_s = ~bus.req[grant_idx_q];
        drop_lim_s = LIMIT_EN && (hcnt_q == HOLD_LIMIT);
        drop_s     = drop_rel_s | drop_req_s | drop_lim_s;
        if (hcnt_q == HOLD_SAT) begin
            hcnt_d = hcnt_q;
        end else begin
            hcnt_d = hcnt_q + 8'd1;
        end
    end

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= 3'd0;
            hcnt_q        <= 8'd0;
            grant_q       <= 8'd0;
            grant_idx_q   <= 3'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    // rel is deliberately ignored here, even on the grant edge.
                    if (any_req_s) begin
                        grant_q       <= 8'd1 << sel_idx_s;
                        grant_idx_q   <= sel_idx_s;
                        grant_valid_q <= 1'b1;
                        hcnt_q        <= 8'd1;
                        state_q       <= GRANTED;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANTED: begin
                    if (drop_s) begin
                        grant_q       <= 8'd0;
                        grant_valid_q <= 1'b0;
                        ptr_q         <= grant_idx_q + 3'd1;
                        // Pulse only when the hold limit alone forced the drop.
                        timeout_q     <= drop_lim_s & ~drop_rel_s & ~drop_req_s;
                        state_q       <= IDLE;
                    end else begin
                        hcnt_q    <= hcnt_d;
                        timeout_q <= 1'b0;
                        state_q   <= GRANTED;
                    end
                end
                default: begin
                    grant_q       <= 8'd0;
                    grant_valid_q <= 1'b0;
                    timeout_q     <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end
endmodule
